// File: rtl/plc_byte_serializer.sv
// Byte-to-bit serializer feeding the PLC scrambler: a small byte FIFO followed by a
// start-pulse + 8-bit shift FSM. Each frame lasts 9 cycles, and frames run back-to-back.
module plc_byte_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       start,
    output logic       ser_out,
    output logic       busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StShift
    } state_e;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    state_e     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    logic push;
    logic pop;

    // The full check uses only the registered count, so a pop on the same edge never frees space.
    assign in_ready = ~rst & (count < CW'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign busy     = (state != StIdle) | (count != '0);

    always_comb begin
        pop = 1'b0;
        if (count != '0) begin
            pop = (state == StIdle) || (state == StShift && bit_cnt == 3'd7);
        end
    end

    function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] idx);
        return LSB_FIRST ? b[idx] : b[3'd7 - idx];
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // bit_cnt always names the bit currently presented on ser_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            bit_cnt <= '0;
            shreg   <= '0;
            start   <= 1'b0;
            ser_out <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    start   <= 1'b0;
                    ser_out <= 1'b0;
                    if (pop) begin
                        shreg   <= mem[rptr];
                        bit_cnt <= '0;
                        start   <= 1'b1;
                        state   <= StStart;
                    end
                end
                StStart: begin
                    start   <= 1'b0;
                    ser_out <= pick_bit(shreg, 3'd0);
                    bit_cnt <= '0;
                    state   <= StShift;
                end
                StShift: begin
                    if (bit_cnt != 3'd7) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        ser_out <= pick_bit(shreg, bit_cnt + 3'd1);
                    end else begin
                        ser_out <= 1'b0;
                        if (pop) begin
                            shreg   <= mem[rptr];
                            bit_cnt <= '0;
                            start   <= 1'b1;
                            state   <= StStart;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: begin
                    start   <= 1'b0;
                    ser_out <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule
